// File: rtl/gates_checker.sv
// gates_checker: self-test sequencer for the two-input logic-gates block.
// Steps {a,b} through 00,01,10,11, holds each vector HOLD_CYCLES cycles, then
// samples the gate outputs for one cycle and records mismatches.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     run request, honoured only in IDLE or DONE
//   y[3:0]    gate outputs read back: [0]=AND [1]=OR [2]=XOR [3]=NAND
//   a, b      gate inputs (registered)
//   busy      run in progress (DRIVE or SAMPLE)
//   done      run finished, results valid
//   pass      done with no mismatching vector
//   fail_vec  bit i set when vector i = {a,b} mismatched
module gates_checker #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fail_q, fail_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [3:0]       exp_y;
  logic             mismatch;

  // Expected gate response for the vector currently held on a/b.
  assign exp_y = {~(a_q & b_q), a_q ^ b_q, a_q | b_q, a_q & b_q};
  // Case inequality so an unknown y is flagged as a mismatch in simulation.
  assign mismatch = (y !== exp_y);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      fail_q  <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: sequencing, hold counter and sticky mismatch record.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 2'd0;
          cnt_d   = CNT_LOAD;
          fail_d  = 4'd0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          fail_d[vec_q] = 1'b1;
        end
        if (vec_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
          vec_d   = vec_q + 2'd1;
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a plain flop.
  always_comb begin
    a_d    = 1'b0;
    b_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    pass_d = 1'b0;
    case (state_d)
      S_DRIVE, S_SAMPLE: begin
        a_d    = vec_d[1];
        b_d    = vec_d[0];
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        pass_d = (fail_d == 4'd0);
      end
      default: ;
    endcase
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gates_checker.sv
// tb_gates_checker: randomized self-checking bench for gates_checker.
// Two instances (HOLD_CYCLES=4 and 1) each close the loop through a gates
// model with programmable stuck-at faults; expected timing and fail_vec come
// from arithmetic on the run position and an explicit walk of the 4 vectors.
module tb_gates_checker;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b00;
  logic [1:0] start = 2'b00;
  logic [1:0] a_o, b_o, busy_o, done_o, pass_o;
  logic [3:0] fail_o [2];
  logic [3:0] y_i    [2];
  logic [3:0] sa0    [2];
  logic [3:0] sa1    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gates_checker #(.HOLD_CYCLES(4)) dut0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .y(y_i[0]),
    .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .fail_vec(fail_o[0])
  );

  gates_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .y(y_i[1]),
    .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .fail_vec(fail_o[1])
  );

  function automatic logic [3:0] gates(input logic a, input logic b);
    return {~(a & b), a ^ b, a | b, a & b};
  endfunction

  // Gates block under test: ideal gates with stuck-at-0/1 masks applied.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      y_i[i] = (gates(a_o[i], b_o[i]) & ~sa0[i]) | sa1[i];
    end
  end

  // Reference: which of the four vectors the faulty gates get wrong.
  function automatic logic [3:0] exp_fail(input logic [3:0] m0, input logic [3:0] m1);
    logic [3:0] r;
    logic [1:0] v;
    r = 4'd0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (((gates(v[1], v[0]) & ~m0) | m1) != gates(v[1], v[0])) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Packed view {busy,done,pass,a,b,fail_vec} of one instance.
  function automatic logic [8:0] status(input int idx);
    return {busy_o[idx], done_o[idx], pass_o[idx], a_o[idx], b_o[idx], fail_o[idx]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    check($sformatf("%s[%0d]", tag, idx), 32'(status(idx)), 32'd0);
  endtask

  // One run: start pulse, cycle-by-cycle check of a/b/busy/done/fail_vec,
  // optional ignored start pulse in vector 1, optional reset at cycle abort_at.
  task automatic run(input int idx, input int h, input bit poke, input int abort_at);
    int          total;
    int          v;
    logic [3:0]  ef;
    logic [3:0]  seen;
    logic [1:0]  vb;
    total = 4 * (h + 1);
    ef    = exp_fail(sa0[idx], sa1[idx]);
    start[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[idx] = 1'b0;
    for (int n = 0; n < total; n++) begin
      v    = n / (h + 1);
      vb   = 2'(v);
      seen = ef & 4'((1 << v) - 1);
      check($sformatf("run[%0d] h=%0d n=%0d", idx, h, n), 32'(status(idx)),
            32'({1'b1, 1'b0, 1'b0, vb[1], vb[0], seen}));
      if (n == abort_at) begin
        rst[idx] = 1'b1;
        #1;
        check_idle(idx, $sformatf("abort n=%0d", n));
        @(negedge clk);
        rst[idx] = 1'b0;
        @(negedge clk);
        check_idle(idx, "after_abort");
        return;
      end
      start[idx] = poke && (n == h + 2);
      @(negedge clk);
    end
    start[idx] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("done[%0d] h=%0d k=%0d", idx, h, k), 32'(status(idx)),
            32'({1'b0, 1'b1, (ef == 4'd0), 1'b0, 1'b0, ef}));
      @(negedge clk);
    end
  endtask

  initial begin
    int idx;
    int gap;
    sa0[0] = 4'd0; sa0[1] = 4'd0;
    sa1[0] = 4'd0; sa1[1] = 4'd0;

    // Reset before any clock edge must clear outputs immediately.
    #1 rst = 2'b11;
    #1 check_idle(0, "reset_async");
    check_idle(1, "reset_async");
    @(negedge clk);
    rst = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle(0, $sformatf("idle c=%0d", i));
    end

    // Directed runs.
    run(0, 4, 1'b0, -1);
    sa0[0] = 4'b0100;
    run(0, 4, 1'b1, -1);
    check("fault_xor_vec", 32'(fail_o[0]), 32'h6);
    sa0[0] = 4'd0;
    run(0, 4, 1'b0, -1);
    run(0, 4, 1'b0, 11);
    run(0, 4, 1'b0, -1);
    run(1, 1, 1'b0, -1);
    sa1[1] = 4'b0001;
    run(1, 1, 1'b1, -1);

    // Random fault masks, instance choice, idle gaps and ignored start pulses.
    for (int it = 0; it < 10; it++) begin
      idx = int'($urandom_range(0, 1));
      sa0[idx] = 4'($urandom);
      sa1[idx] = 4'($urandom) & ~sa0[idx];
      if ($urandom_range(0, 2) == 0) begin
        sa0[idx] = 4'd0;
        sa1[idx] = 4'd0;
      end
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) @(negedge clk);
      run(idx, (idx == 0) ? 4 : 1, 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
